// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0
// prefixes into single key events, tracks the held key and keeps a two-digit
// BCD press counter.
module ps2_key_decoder #(
  parameter int REPEAT_FILTER = 1,
  parameter int ACK_WAIT      = 1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  output logic       ps2_nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_repeat,
  output logic       key_down,
  output logic [7:0] held_code,
  output logic [3:0] press_cnt_lo,
  output logic [3:0] press_cnt_hi
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(ACK_WAIT - 1);

  state_t     r_state, w_next;
  logic [1:0] r_wait_cnt;
  logic [7:0] r_byte;
  logic       r_ext_pend, r_brk_pend;
  logic       r_key_valid, r_key_ext, r_key_release, r_key_repeat;
  logic [7:0] r_key_code;
  logic       r_key_down, r_held_ext;
  logic [7:0] r_held_code;
  logic [3:0] r_cnt_lo, r_cnt_hi;

  logic w_in_ack, w_is_e0, w_is_f0, w_is_err, w_is_key;
  logic w_same, w_repeat, w_count;

  // Decode of the latched byte; only meaningful during the ACK cycle.
  assign w_in_ack = (r_state == S_ACK);
  assign w_is_e0  = (r_byte == 8'hE0);
  assign w_is_f0  = (r_byte == 8'hF0);
  assign w_is_err = (r_byte == 8'h00) || (r_byte == 8'hFF);
  assign w_is_key = w_in_ack && !w_is_e0 && !w_is_f0 && !w_is_err;
  assign w_same   = (r_held_code == r_byte) && (r_held_ext == r_ext_pend);
  assign w_repeat = !r_brk_pend && r_key_down && w_same && (REPEAT_FILTER != 0);
  assign w_count  = w_is_key && !r_brk_pend && !w_repeat;

  // Handshake state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: one pop per byte, then ACK_WAIT cycles before ready is resampled.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ps2_ready) w_next = S_ACK;
      S_ACK:   w_next = S_WAIT;
      S_WAIT:  if (r_wait_cnt == WAIT_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counts cycles spent in WAIT; parked at zero elsewhere.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                  r_wait_cnt <= '0;
    else if (r_state != S_WAIT) r_wait_cnt <= '0;
    else                        r_wait_cnt <= r_wait_cnt + 2'd1;
  end

  // Capture the FIFO head when leaving IDLE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                              r_byte <= '0;
    else if (r_state == S_IDLE && ps2_ready) r_byte <= ps2_data;
  end

  // Prefix flags: set by E0/F0, cleared by any key code or error byte.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_in_ack) begin
      if (w_is_e0)      r_ext_pend <= 1'b1;
      else if (w_is_f0) r_brk_pend <= 1'b1;
      else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  // Event fields and held-key tracking, updated at the end of ACK.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_key_valid   <= 1'b0;
      r_key_code    <= '0;
      r_key_ext     <= 1'b0;
      r_key_release <= 1'b0;
      r_key_repeat  <= 1'b0;
      r_key_down    <= 1'b0;
      r_held_code   <= '0;
      r_held_ext    <= 1'b0;
    end else begin
      r_key_valid <= w_is_key;
      if (w_is_key) begin
        r_key_code    <= r_byte;
        r_key_ext     <= r_ext_pend;
        r_key_release <= r_brk_pend;
        r_key_repeat  <= w_repeat;
        if (!r_brk_pend) begin
          r_held_code <= r_byte;
          r_held_ext  <= r_ext_pend;
          r_key_down  <= 1'b1;
        end else if (w_same) begin
          // Break of the held key; held_code is kept for the display.
          r_key_down <= 1'b0;
        end
      end
    end
  end

  // Two-digit BCD press counter, wraps 99 -> 00.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt_lo <= '0;
      r_cnt_hi <= '0;
    end else if (w_count) begin
      if (r_cnt_lo == 4'd9) begin
        r_cnt_lo <= '0;
        r_cnt_hi <= (r_cnt_hi == 4'd9) ? 4'd0 : r_cnt_hi + 4'd1;
      end else begin
        r_cnt_lo <= r_cnt_lo + 4'd1;
      end
    end
  end

  // Pop strobe decoded straight from the state register.
  assign ps2_nextdata_n = (r_state != S_ACK);
  assign key_valid      = r_key_valid;
  assign key_code       = r_key_code;
  assign key_ext        = r_key_ext;
  assign key_release    = r_key_release;
  assign key_repeat     = r_key_repeat;
  assign key_down       = r_key_down;
  assign held_code      = r_held_code;
  assign press_cnt_lo   = r_cnt_lo;
  assign press_cnt_hi   = r_cnt_hi;

endmodule
